// File: rtl/bin2decdigi_seq.sv
// rtl/bin2decdigi_seq.sv - sequential binary to 7-segment decimal display encoder
//
// Converts an unsigned WIDTH-bit value to DIGITS seven-segment codes using a
// serial double-dabble (one bit per clock), then encodes the BCD result.
//
// Ports:
//   clock      - sole clock, rising edge
//   rst_n      - asynchronous active-low reset
//   in_valid   - bin holds a value to convert
//   in_ready   - block can accept a value (high only in IDLE)
//   bin        - unsigned binary input, sampled only on the accepting edge
//   out_valid  - digi/overflow hold a finished result
//   out_ready  - consumer takes the result
//   digi       - segment codes, digi[7*i+6:7*i] is decimal digit i (0 = units)
//   overflow   - value needs more than DIGITS digits

module bin2decdigi_seq #(
    parameter int WIDTH    = 16,
    parameter int DIGITS   = 5,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7*DIGITS-1:0]   digi,
    output logic                  overflow
);

    // WIDTH/3+1 nibbles always cover 2^WIDTH-1; NP pads to DIGITS when the
    // display is wider than the BCD register so every digit has a source.
    localparam int NI = WIDTH / 3 + 1;
    localparam int NP = (DIGITS > NI) ? DIGITS : NI;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CONV, ENC, DONE} state_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      shift_q, shift_d;
    logic [4*NI-1:0]       bcd_q, bcd_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [7*DIGITS-1:0]   digi_q, digi_d;
    logic                  ovf_q, ovf_d;
    logic                  out_valid_q, out_valid_d;

    logic [4*NI-1:0]       bcd_adj;
    logic [7*DIGITS-1:0]   enc_digi;
    logic                  enc_ovf;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0111111;
            4'd1:    seg7 = 7'b0011000;
            4'd2:    seg7 = 7'b1110110;
            4'd3:    seg7 = 7'b1111100;
            4'd4:    seg7 = 7'b1011001;
            4'd5:    seg7 = 7'b1101101;
            4'd6:    seg7 = 7'b1101111;
            4'd7:    seg7 = 7'b0111000;
            4'd8:    seg7 = 7'b1111111;
            4'd9:    seg7 = 7'b1111101;
            default: seg7 = 7'b0000000;
        endcase
    endfunction

    // Double-dabble correction: a nibble >= 5 would exceed 9 after doubling.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NI; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Result encoding. Scanning from the top digit down, "seen" goes high at
    // the first nonzero displayed digit; everything above it is blanked.
    always_comb begin
        logic [4*NP-1:0] bcd_pad;
        logic            seen;
        bcd_pad  = (4*NP)'(bcd_q);
        enc_ovf  = 1'b0;
        enc_digi = '0;
        seen     = 1'b0;
        for (int i = 0; i < NP; i++) begin
            if (i >= DIGITS && bcd_pad[4*i +: 4] != 4'd0) begin
                enc_ovf = 1'b1;
            end
        end
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (bcd_pad[4*i +: 4] != 4'd0) begin
                seen = 1'b1;
            end
            if (seen || i == 0 || !BLANK_LZ) begin
                enc_digi[7*i +: 7] = seg7(bcd_pad[4*i +: 4]);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        digi_d      = digi_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shift_d = bin;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                // {bcd, shift} shifted left as one register.
                bcd_d   = (bcd_adj << 1) | (4*NI)'(shift_q[WIDTH-1]);
                shift_d = shift_q << 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ENC;
                end
            end
            ENC: begin
                digi_d      = enc_digi;
                ovf_d       = enc_ovf;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            digi_q      <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            digi_q      <= digi_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign digi      = digi_q;
    assign overflow  = ovf_q;

endmodule
